// File: rtl/seven_seg_pkg.sv
// Shared types and select encodings for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } digits_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_A    = 4'b0001;
  localparam logic [3:0] SEL_B    = 4'b0010;
  localparam logic [3:0] SEL_C    = 4'b0100;
  localparam logic [3:0] SEL_D    = 4'b1000;

  function automatic logic [3:0] idx_to_onehot(input digit_idx_t idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = SEL_A;
      2'd1:    sel = SEL_B;
      2'd2:    sel = SEL_C;
      default: sel = SEL_D;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot cycle counter; flags the last blank cycle and the last cycle of the slot.
module seg_slot_timer #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_blank_done_c,
  output logic o_slot_done_c
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  // Wraps to zero on the terminal count rather than saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_slot_done_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_blank_done_c = (BLANK_CYCLES != 0) && (r_cnt == BLANK_LAST);
  assign o_slot_done_c  = (r_cnt == SLOT_LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Digit scan sequencer for the hex seven-segment decoder with frame-aligned value commit.
// Optional leading-zero suppression: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic [3:0]  displayA,
  output logic [3:0]  displayB,
  output logic [3:0]  displayC,
  output logic [3:0]  displayD,
  output logic [3:0]  select,
  output logic        frame_done
);

  state_e     r_state, w_state_nxt;
  digit_idx_t r_idx, w_idx_nxt;
  logic [3:0] r_select, w_sel_nxt;
  logic       r_frame_done, w_fd_nxt;
  digits_t    r_disp, w_disp_nxt;
  logic [15:0] r_pend, w_pend_nxt;
  logic       r_pflag, w_pflag_nxt;
  logic       w_blank_done, w_slot_done, w_boundary, w_lz;

  seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_clear        ((r_state == IDLE) || !enable),
    .i_en           (r_state != IDLE),
    .o_blank_done_c (w_blank_done),
    .o_slot_done_c  (w_slot_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_select     <= SEL_NONE;
      r_frame_done <= 1'b0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pflag      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_select     <= w_sel_nxt;
      r_frame_done <= w_fd_nxt;
      r_disp       <= w_disp_nxt;
      r_pend       <= w_pend_nxt;
      r_pflag      <= w_pflag_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_disp_nxt  = r_disp;
    w_pend_nxt  = r_pend;
    w_pflag_nxt = r_pflag;
    w_lz        = 1'b0;
    w_boundary  = (r_state == SHOW) && (r_idx == 2'd3) && w_slot_done && enable;
    w_fd_nxt    = w_boundary;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_idx_nxt   = '0;
          w_state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end
      end
      BLANK: begin
        if (w_blank_done) w_state_nxt = SHOW;
      end
      SHOW: begin
        if (w_slot_done) begin
          w_idx_nxt   = r_idx + digit_idx_t'(1);
          w_state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end

    // Load in the boundary cycle bypasses pending; idle loads commit immediately.
    if (load) w_pend_nxt = digits_in;
    if ((r_state == IDLE) && load) begin
      w_disp_nxt  = digits_in;
      w_pflag_nxt = 1'b0;
    end else if (w_boundary) begin
      if (load)         w_disp_nxt = digits_in;
      else if (r_pflag) w_disp_nxt = r_pend;
      w_pflag_nxt = 1'b0;
    end else if (load) begin
      w_pflag_nxt = 1'b1;
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    case (w_idx_nxt)
      2'd0:    w_lz = (w_disp_nxt.a == 4'h0);
      2'd1:    w_lz = ({w_disp_nxt.a, w_disp_nxt.b} == 8'h00);
      2'd2:    w_lz = ({w_disp_nxt.a, w_disp_nxt.b, w_disp_nxt.c} == 12'h000);
      default: w_lz = 1'b0;
    endcase
`else
    w_lz = 1'b0;
`endif

    w_sel_nxt = ((w_state_nxt == SHOW) && !w_lz) ? idx_to_onehot(w_idx_nxt) : SEL_NONE;
  end

  assign select     = r_select;
  assign frame_done = r_frame_done;
  assign displayA   = r_disp.a;
  assign displayB   = r_disp.b;
  assign displayC   = r_disp.c;
  assign displayD   = r_disp.d;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a time-in-frame reference model.
module tb_seven_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  displayA, displayB, displayC, displayD, select;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .displayA   (displayA),
    .displayB   (displayB),
    .displayC   (displayC),
    .displayD   (displayD),
    .select     (select),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scan position is simply cycles elapsed since scanning started.
  bit          m_idle = 1'b1;
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pflag = 1'b0;
  bit          m_fd = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_select();
    int slot;
    if (m_idle || (m_t % RD) < BC) return 4'b0000;
    slot = (m_t / RD) % 4;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (slot != 3 && (m_disp >> (12 - 4 * slot)) == 16'h0) return 4'b0000;
`endif
    return 4'(1 << slot);
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pflag = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [15:0] din);
    bit boundary;
    boundary = !m_idle && en && ((m_t % FRAME) == FRAME - 1);
    if (m_idle) begin
      if (ld) begin m_disp = din; m_pflag = 1'b0; end
    end else if (boundary) begin
      if (ld) m_disp = din;
      else if (m_pflag) m_disp = m_pend;
      m_pflag = 1'b0;
    end else if (ld) begin
      m_pflag = 1'b1;
    end
    if (ld) m_pend = din;
    m_fd = boundary;
    if (!en) m_idle = 1'b1;
    else if (m_idle) begin m_idle = 1'b0; m_t = 0; end
    else m_t++;
  endtask

  task automatic check_outputs();
    check("select", {12'h0, select}, {12'h0, exp_select()});
    check("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    check("display", {displayA, displayB, displayC, displayD}, m_disp);
  endtask

  task automatic cyc(input bit en, input bit ld, input logic [15:0] din);
    @(negedge clk);
    check_outputs();
    enable = en; load = ld; digits_in = din;
    @(posedge clk);
    model_step(en, ld, din);
  endtask

  task automatic wait_pos(input int slot, input int phase);
    bit found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (!m_idle && (m_t % FRAME) == slot * RD + phase) begin found = 1'b1; break; end
      cyc(1'b1, 1'b0, 16'h0);
    end
    if (!found) check("wait_timeout", 16'h0, 16'h1);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    d = 16'($urandom);
    for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'h0;
    return d;
  endfunction

  initial begin
    #12;
    check("rst_select", {12'h0, select}, 16'h0);
    check("rst_fd", {15'h0, frame_done}, 16'h0);
    check("rst_display", {displayA, displayB, displayC, displayD}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Basic scan with an idle commit
    cyc(1'b0, 1'b1, 16'h1A3F);
    for (int i = 0; i < 2 * FRAME + 3; i++) cyc(1'b1, 1'b0, 16'h0);

    // Tear-free update: last pending load wins at the frame boundary
    wait_pos(1, 3);
    cyc(1'b1, 1'b1, 16'h2222);
    wait_pos(2, 4);
    cyc(1'b1, 1'b1, 16'h3333);
    wait_pos(3, RD - 1);
    cyc(1'b1, 1'b0, 16'h0);
    #1;
    check("tear_free", {displayA, displayB, displayC, displayD}, 16'h3333);
    check("tear_free_fd", {15'h0, frame_done}, 16'h1);

    // Load coinciding with the boundary
    wait_pos(3, RD - 1);
    cyc(1'b1, 1'b1, 16'h4567);
    #1;
    check("collision", {displayA, displayB, displayC, displayD}, 16'h4567);
    for (int i = 0; i < FRAME + 2; i++) cyc(1'b1, 1'b0, 16'h0);

    // Enable drop mid-slot and restart
    wait_pos(1, 4);
    cyc(1'b0, 1'b0, 16'h0);
    #1;
    check("drop_select", {12'h0, select}, 16'h0);
    check("drop_fd", {15'h0, frame_done}, 16'h0);
    for (int i = 0; i < FRAME + 4; i++) cyc(1'b1, 1'b0, 16'h0);

    // Leading-zero patterns committed from idle
    cyc(1'b0, 1'b1, 16'h0050);
    for (int i = 0; i < FRAME + 2; i++) cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < FRAME + 2; i++) cyc(1'b1, 1'b0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 97), ($urandom_range(0, 15) == 0), rand_digits());
    end

    // Asynchronous reset in SHOW of digit C
    wait_pos(2, 4);
    #2;
    reset = 1'b1;
    enable = 1'b0; load = 1'b0;
    #1;
    check("areset_select", {12'h0, select}, 16'h0);
    check("areset_fd", {15'h0, frame_done}, 16'h0);
    check("areset_display", {displayA, displayB, displayC, displayD}, 16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < FRAME + 4; i++) cyc(1'b1, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller that sequences the existing hex-to-seven-segment mux/decoder. It holds a 16-bit, four-nibble display value and drives the decoder's one-hot select so that one digit lights at a time, A through D, at a fixed refresh rate. A blanking gap separates digits to suppress ghosting. New values are committed only at frame boundaries so a frame never shows a mix of old and new digits.

Parameters:
REFRESH_DIV, 25000, clock cycles per digit slot (blank plus show); must be at least 2.
BLANK_CYCLES, 256, cycles at the start of each slot with select = 4'b0000; must be less than REFRESH_DIV. A value of 0 skips BLANK.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  scanning enabled when high
load  input  1  one-cycle strobe; captures digits_in
digits_in  input  16  [15:12] = digit A (leftmost) ... [3:0] = digit D
displayA  output  4  committed digit A nibble, to the decoder
displayB  output  4  committed digit B nibble
displayC  output  4  committed digit C nibble
displayD  output  4  committed digit D nibble
select  output  4  one-hot digit select to the decoder; bit0 = A ... bit3 = D; 4'b0000 = all off
frame_done  output  1  one-cycle pulse at the end of digit D's show phase

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE, slot counter 0, digit index 0, select 4'b0000, frame_done 0, displayA-D 4'h0, pending register 16'h0000, pending flag 0.
- State machine states: IDLE, BLANK, SHOW.
- IDLE: select = 0000. If enable is sampled high, the next state is BLANK with digit index 0 and counter 0.
- BLANK:
  - select = 0000.
  - Counter increments each cycle.
  - At count BLANK_CYCLES-1, go to SHOW and continue the count.
- SHOW:
  - select = one-hot of the digit index.
  - At count REFRESH_DIV-1, clear the counter and advance the index (modulo 4, 3 wraps to 0), then go to BLANK, or straight to SHOW when BLANK_CYCLES = 0.
- Slot and frame timing: each slot lasts exactly REFRESH_DIV cycles; a frame lasts 4*REFRESH_DIV cycles.
- frame_done: asserted in the cycle after the last SHOW cycle of digit D, coincident with BLANK of digit A.
- enable low in any state: next cycle goes to IDLE, select = 0000, counter and index cleared, no frame_done pulse. Re-enable restarts at digit A.
- load handling:
  - load captures digits_in into the pending register and sets the pending flag.
  - A later load before commit overwrites the pending value (last load wins).
- Commit rules:
  - When scanning, commit happens at the frame boundary (the same edge that raises frame_done): pending is copied to displayA-D and the flag is cleared.
  - When load coincides with the boundary, the digits_in from that cycle are committed (bypass).
  - In IDLE, a load commits on the next edge.
- Counter width: clog2(REFRESH_DIV). Reaching terminal count saturates nothing; the counter resets in the same cycle it hits terminal count.
- Reset mid-operation: immediate return to reset values, and the pending value is lost.

Optional Feature:
Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: during each SHOW slot whose committed digit is 0 and all more-significant digits are also 0, select is 0000.
  - Digit D is never suppressed, so 16'h0000 shows a single "0" on D.
  - 16'h0050 suppresses A and B only.
  - Slot timing and frame_done are unchanged.
- Undefined: all four digits are always shown.

Decomposition:
- Package seven_seg_pkg:
  - state enum (IDLE, BLANK, SHOW)
  - 2-bit digit-index type
  - select constants SEL_NONE = 4'b0000, SEL_A = 4'b0001, SEL_B = 4'b0010, SEL_C = 4'b0100, SEL_D = 4'b1000
  - function index-to-one-hot
- One sub-module: seg_slot_timer.
  - Parameterised up-counter with clear and enable inputs.
  - Outputs are the blank-done and slot-done terminal pulses.
  - Instanced once.

Test Plan:
Use REFRESH_DIV=8 and BLANK_CYCLES=2 throughout.
1. Reset: assert reset mid-SHOW of digit C -> select = 0000, frame_done = 0, and displayA-D = 0 asynchronously; after release with enable=0, select stays 0000.
2. Basic scan: load 16'h1A3F, then enable=1 -> in IDLE the load commits on the next edge, so displayA-D = 1, A, 3, F. Per slot, select = 0000 for 2 cycles then 6 cycles of 0001, 0010, 0100, 1000 in turn; frame_done pulses once every 32 cycles.
3. Tear-free update: while scanning, load 16'h2222 during digit B, then 16'h3333 during digit C -> displayA-D stay 1A3F until the boundary, then become 3333 on the frame_done edge.
4. Boundary collision: load 16'h4567 in the exact frame_done cycle -> 4567 is committed at that edge and the pending flag is clear afterwards.
5. Enable drop: deassert enable during SHOW of digit B -> next cycle select = 0000 with no frame_done; re-enable restarts with digit A's BLANK.
6. Leading-zero blanking (macro defined): commit 16'h0050 -> select is 0000 during the A and B SHOW slots, and 0100 and 1000 during C and D; commit 16'h0000 -> only the D slot lights.
